bingo_game_ctrl: RTL and testbench
==================================

# bingo_game_ctrl

Game sequencer for the BinGo keypad datapath. It watches the keyboard controller's digit-pair outputs, assembles two-digit decimal numbers, loads them into a player card, and arms, starts and runs the game. During play it treats each entered number as a draw, marks matches on the card, and declares bingo when every card entry is marked. It sits directly after the keyboard controller and drives the status/display logic.

## Interface
- CARD_SIZE, 8: number of card entries (1..16).
- MAX_NUM, 75: largest legal number; legal range is 1..MAX_NUM (MAX_NUM ≤ 99).
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset; one clock domain only.
- key_count  in  2  keypress counter from the keyboard controller; sequence 0,1,2,1,2,…; any change marks one keypress.
- key_pair  in  8  last two key codes; [3:0] newest, [7:4] previous.
- state  out  2  LOAD=0, ARMED=1, PLAY=2, DONE=3.
- card_count  out  5  entries stored (0..CARD_SIZE).
- marks  out  CARD_SIZE  bit i set when entry i has been drawn.
- hit_count  out  5  popcount of marks.
- last_num  out  7  last accepted number in binary.
- hit  out  1  one-cycle pulse: a draw marked an entry.
- reject  out  1  one-cycle pulse: a key event was refused.
- bingo  out  1  level, high in DONE.

## Operation
- Key event: key_count ≠ key_count_q, where key_count_q is a registered copy (reset 0). Decode order on an event, by newest code n = key_pair[3:0]:
  - n = 4'hB (START): LOAD → reject. ARMED → PLAY. PLAY → ignored, no pulse. DONE → LOAD with card, marks and counters cleared.
  - n = 4'hA (ERASE): LOAD with card_count > 0 → card_count−1. Otherwise reject.
  - n = 4'hC..4'hF: reject.
  - Digit with key_count = 1: no action (first digit of a pair).
  - Digit with key_count = 2: pair complete. Tens t = key_pair[7:4]. If t > 9 → reject. v = t·10 + n, as (t<<3)+(t<<1)+n, 7 bits. v = 0 or v > MAX_NUM → reject.
- LOAD, valid v: if v equals any stored entry → reject. Otherwise store at index card_count, increment, last_num ← v. Reaching CARD_SIZE → ARMED.
- ARMED, valid v: reject (card is full; only ERASE or START accepted). ERASE in ARMED: card_count−1, back to LOAD.
- PLAY, valid v: parallel compare against all stored entries. Match on an unmarked entry → set mark, hit pulse. Already-marked or no match → no pulse. last_num ← v in all cases. All CARD_SIZE marks set → DONE.
- DONE: number events ignored with no pulse. Only START is acted on.

## Timing
- Reset (asynchronous): state=LOAD, card_count=0, marks=0, hit_count=0, last_num=0, hit=0, reject=0, bingo=0, key_count_q=0, card entries 0.
- Latency: if key_count changes at edge E, all updates and pulses appear after edge E+1. Pulses last exactly one cycle.
- Events are at most one per cycle by construction. A key_count change on every cycle is handled back to back.
- Final mark: DONE and bingo are asserted in the same cycle as the hit pulse.
- Reset mid-game: clears immediately. A key_count value held across reset release counts as an event if it is nonzero. The bench releases reset with key_count = 0.

## Structure
- Package bingo_pkg holds the state encoding, KEY_ERASE=4'hA, KEY_START=4'hB, and the digit limit 9.
- Sub-module bingo_card holds the CARD_SIZE×7-bit entry storage, the marks register, the parallel match vector, the duplicate check and the popcount.
- The top level holds event detection, BCD-to-binary conversion, range checks and the FSM.

## Test plan
- Load 8 keys 1..8 as pairs "01".."08": card_count steps 1..8, no reject, state=ARMED after the 8th pair, last_num=8.
- In LOAD, enter "05" twice: second entry gives reject and card_count unchanged. Enter "00", "76", "9A"-style tens 4'hB: each gives reject.
- ERASE after 3 entries gives card_count=2. ERASE in ARMED gives card_count=7 and state=LOAD. ERASE at 0 gives reject.
- START in LOAD gives reject. START in ARMED gives PLAY. Draw "03" gives hit and marks[2]=1. Draw "03" again gives no hit and hit_count=1. Draw "40" gives no hit and last_num=40.
- Draw all 8 card numbers: 8th hit pulse coincides with state=DONE and bingo=1. Draw in DONE is ignored. START clears everything to LOAD.
- Assert rst mid-PLAY with 4 marks: all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/bingo_pkg.sv
// Shared encodings for the BinGo game sequencer.
package bingo_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ERASE = 4'hA;
    localparam logic [3:0] KEY_START = 4'hB;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // t*10 + n; only meaningful once t has been range-checked
    function automatic logic [6:0] bcd2bin(input logic [3:0] t,
                                           input logic [3:0] n);
        return ({3'b0, t} << 3) + ({3'b0, t} << 1) + {3'b0, n};
    endfunction

endpackage

// File: rtl/bingo_card.sv
// Player card: entry storage, draw marks, match/duplicate compare, popcount.
module bingo_card
    import bingo_pkg::*;
#(
    parameter int CARD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [4:0]           wr_idx,
    input  logic [6:0]           wr_val,
    input  logic                 mark_en,
    input  logic [6:0]           num,
    input  logic [4:0]           count,
    output logic [CARD_SIZE-1:0] match,
    output logic                 dup,
    output logic [CARD_SIZE-1:0] marks,
    output logic [4:0]           hit_count
);

    logic [6:0]           entry_q [CARD_SIZE];
    logic [CARD_SIZE-1:0] marks_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CARD_SIZE; i++) entry_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < CARD_SIZE; i++) entry_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < CARD_SIZE; i++)
                if (wr_idx == 5'(i)) entry_q[i] <= wr_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            marks_q <= '0;
        else if (clr)
            marks_q <= '0;
        else if (mark_en)
            marks_q <= marks_q | match;
    end

    // Entries at or above count are stale after an erase and never match
    always_comb begin
        match     = '0;
        hit_count = '0;
        for (int i = 0; i < CARD_SIZE; i++) begin
            match[i]  = (5'(i) < count) && (entry_q[i] == num);
            hit_count = hit_count + 5'(marks_q[i]);
        end
    end

    assign dup   = |match;
    assign marks = marks_q;

endmodule

// File: rtl/bingo_game_ctrl.sv
// BinGo sequencer: key event decode, number assembly and game FSM.
module bingo_game_ctrl
    import bingo_pkg::*;
#(
    parameter int CARD_SIZE = 8,
    parameter int MAX_NUM   = 75
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           key_count,
    input  logic [7:0]           key_pair,
    output logic [1:0]           state,
    output logic [4:0]           card_count,
    output logic [CARD_SIZE-1:0] marks,
    output logic [4:0]           hit_count,
    output logic [6:0]           last_num,
    output logic                 hit,
    output logic                 reject,
    output logic                 bingo
);

    state_t               state_q, state_d;
    logic [1:0]           kc_q;
    logic [4:0]           cnt_q, cnt_d;
    logic [6:0]           last_q, last_d;
    logic                 hit_q, hit_d, rej_q, rej_d;
    logic                 clr, wr_en, mark_en, dup;
    logic [CARD_SIZE-1:0] match, fresh;
    logic [3:0]           t, n;
    logic [6:0]           v;
    logic                 ev, pair, digit, all_marked;
    logic                 is_start, is_erase, is_bad;
    logic                 is_first, is_oor, is_num;

    assign t     = key_pair[7:4];
    assign n     = key_pair[3:0];
    assign v     = bcd2bin(t, n);
    assign ev    = key_count != kc_q;
    assign pair  = key_count == 2'd2;
    assign digit = n <= DIGIT_MAX;

    // Mutually exclusive event classes
    assign is_start = n == KEY_START;
    assign is_erase = n == KEY_ERASE;
    assign is_bad   = n > KEY_START;
    assign is_first = digit && !pair;
    assign is_oor   = digit && pair &&
                      (t > DIGIT_MAX || v == 7'd0 || v > 7'(MAX_NUM));
    assign is_num   = digit && pair && !is_oor;

    assign fresh      = match & ~marks;
    assign all_marked = &(marks | match);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        hit_d   = 1'b0;
        rej_d   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        mark_en = 1'b0;
        if (ev) begin
            unique case (1'b1)
                is_start: begin
                    case (state_q)
                        ST_LOAD:  rej_d = 1'b1;
                        ST_ARMED: state_d = ST_PLAY;
                        ST_DONE: begin
                            state_d = ST_LOAD;
                            cnt_d   = '0;
                            last_d  = '0;
                            clr     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                is_erase: begin
                    if (state_q == ST_LOAD && cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else if (state_q == ST_ARMED) begin
                        cnt_d   = cnt_q - 5'd1;
                        state_d = ST_LOAD;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
                is_bad, is_oor: rej_d = 1'b1;
                is_first: ;
                is_num: begin
                    case (state_q)
                        ST_LOAD: begin
                            if (dup) begin
                                rej_d = 1'b1;
                            end else begin
                                wr_en  = 1'b1;
                                cnt_d  = cnt_q + 5'd1;
                                last_d = v;
                                if (cnt_q + 5'd1 == 5'(CARD_SIZE))
                                    state_d = ST_ARMED;
                            end
                        end
                        ST_ARMED: rej_d = 1'b1;
                        ST_PLAY: begin
                            mark_en = 1'b1;
                            last_d  = v;
                            hit_d   = |fresh;
                            if (all_marked) state_d = ST_DONE;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            kc_q    <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            hit_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kc_q    <= key_count;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            hit_q   <= hit_d;
            rej_q   <= rej_d;
        end
    end

    bingo_card #(
        .CARD_SIZE(CARD_SIZE)
    ) u_card (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_idx   (cnt_q),
        .wr_val   (v),
        .mark_en  (mark_en),
        .num      (v),
        .count    (cnt_q),
        .match    (match),
        .dup      (dup),
        .marks    (marks),
        .hit_count(hit_count)
    );

    assign state      = state_q;
    assign card_count = cnt_q;
    assign last_num   = last_q;
    assign hit        = hit_q;
    assign reject     = rej_q;
    assign bingo      = state_q == ST_DONE;

endmodule

// File: tb/tb_bingo_game_ctrl.sv
// Scoreboard bench for bingo_game_ctrl: driver queues expectations,
// monitor checks one cycle after each key event.
module tb_bingo_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_count;
    logic [7:0] key_pair;
    logic [1:0] state;
    logic [4:0] card_count;
    logic [7:0] marks;
    logic [4:0] hit_count;
    logic [6:0] last_num;
    logic       hit;
    logic       reject;
    logic       bingo;

    bingo_game_ctrl #(
        .CARD_SIZE(8),
        .MAX_NUM  (75)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_count (key_count),
        .key_pair  (key_pair),
        .state     (state),
        .card_count(card_count),
        .marks     (marks),
        .hit_count (hit_count),
        .last_num  (last_num),
        .hit       (hit),
        .reject    (reject),
        .bingo     (bingo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [4:0] cnt;
        logic [7:0] mk;
        logic [6:0] last;
        logic       hit;
        logic       rej;
    } exp_t;

    exp_t       q[$];
    string      nq[$];
    exp_t       cur;
    int         checks   = 0;
    int         failures = 0;
    logic [1:0] mon_kc   = 2'd0;

    function automatic exp_t ex(input int st, input int cnt, input int mk,
                                input int last, input int h, input int r);
        exp_t e;
        e.st   = 2'(st);
        e.cnt  = 5'(cnt);
        e.mk   = 8'(mk);
        e.last = 7'(last);
        e.hit  = 1'(h);
        e.rej  = 1'(r);
        return e;
    endfunction

    // Monitor: one response per key_count change
    initial begin
        exp_t        e;
        string       nm;
        logic [4:0]  exp_hc;
        logic        exp_b;
        forever begin
            @(posedge clk);
            if (!rst && key_count != mon_kc) begin
                mon_kc = key_count;
                #1;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got event, required none");
                end else begin
                    e      = q.pop_front();
                    nm     = nq.pop_front();
                    exp_hc = 5'($countones(e.mk));
                    exp_b  = e.st == 2'd3;
                    if ({state, card_count, marks, last_num, hit, reject}
                            !== e || hit_count !== exp_hc || bingo !== exp_b) begin
                        failures++;
                        $display("FAIL %s: got st=%0d cnt=%0d mk=%h last=%0d hit=%b rej=%b hc=%0d bingo=%b, required st=%0d cnt=%0d mk=%h last=%0d hit=%b rej=%b hc=%0d bingo=%b",
                                 nm, state, card_count, marks, last_num, hit,
                                 reject, hit_count, bingo, e.st, e.cnt, e.mk,
                                 e.last, e.hit, e.rej, exp_hc, exp_b);
                    end
                end
            end
        end
    end

    task automatic reset_check(input string nm);
        checks++;
        if ({state, card_count, marks, hit_count, last_num, hit, reject,
             bingo} !== '0) begin
            failures++;
            $display("FAIL %s: got st=%0d cnt=%0d mk=%h hc=%0d last=%0d hit=%b rej=%b bingo=%b, required all zero",
                     nm, state, card_count, marks, hit_count, last_num, hit,
                     reject, bingo);
        end
    endtask

    task automatic key(input int code, input string nm, input exp_t e);
        @(negedge clk);
        key_pair  = {key_pair[3:0], 4'(code)};
        key_count = (key_count == 2'd1) ? 2'd2 : 2'd1;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    function automatic exp_t quiet();
        exp_t e;
        e     = cur;
        e.hit = 1'b0;
        e.rej = 1'b0;
        return e;
    endfunction

    task automatic num2(input int t, input int n, input string nm,
                        input exp_t e);
        key(t, {nm, "_d1"}, quiet());
        key(n, nm, e);
        cur = e;
    endtask

    // Filler digit keeps commands on the second slot of a pair
    task automatic cmd(input int c, input string nm, input exp_t e);
        key(0, {nm, "_fill"}, quiet());
        key(c, nm, e);
        cur = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        key_count = 2'd0;
        key_pair  = 8'h00;
        cur       = '0;
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst = 1'b0;

        num2(0, 1, "ld01", ex(0, 1, 0, 1, 0, 0));
        num2(0, 2, "ld02", ex(0, 2, 0, 2, 0, 0));
        num2(0, 3, "ld03", ex(0, 3, 0, 3, 0, 0));
        cmd(10, "erase3", ex(0, 2, 0, 3, 0, 0));
        num2(0, 3, "ld03b", ex(0, 3, 0, 3, 0, 0));
        num2(0, 5, "ld05", ex(0, 4, 0, 5, 0, 0));
        num2(0, 5, "dup05", ex(0, 4, 0, 5, 0, 1));
        num2(0, 0, "zero", ex(0, 4, 0, 5, 0, 1));
        num2(7, 6, "over76", ex(0, 4, 0, 5, 0, 1));
        key(11, "tensB_start", ex(0, 4, 0, 5, 0, 1));
        key(5, "tensB", ex(0, 4, 0, 5, 0, 1));
        cur = ex(0, 4, 0, 5, 0, 1);
        cmd(11, "start_load", ex(0, 4, 0, 5, 0, 1));
        num2(0, 4, "ld04", ex(0, 5, 0, 4, 0, 0));
        num2(0, 6, "ld06", ex(0, 6, 0, 6, 0, 0));
        num2(0, 7, "ld07", ex(0, 7, 0, 7, 0, 0));
        num2(0, 8, "ld08", ex(1, 8, 0, 8, 0, 0));
        num2(0, 9, "armed09", ex(1, 8, 0, 8, 0, 1));
        cmd(10, "erase_armed", ex(0, 7, 0, 8, 0, 0));
        num2(0, 8, "ld08b", ex(1, 8, 0, 8, 0, 0));
        cmd(11, "start", ex(2, 8, 0, 8, 0, 0));

        num2(0, 3, "draw03", ex(2, 8, 8'h04, 3, 1, 0));
        num2(0, 3, "draw03b", ex(2, 8, 8'h04, 3, 0, 0));
        num2(4, 0, "draw40", ex(2, 8, 8'h04, 40, 0, 0));
        num2(8, 0, "draw80", ex(2, 8, 8'h04, 40, 0, 1));
        num2(0, 1, "draw01", ex(2, 8, 8'h05, 1, 1, 0));
        num2(0, 2, "draw02", ex(2, 8, 8'h07, 2, 1, 0));
        num2(0, 5, "draw05", ex(2, 8, 8'h0F, 5, 1, 0));
        num2(0, 4, "draw04", ex(2, 8, 8'h1F, 4, 1, 0));
        num2(0, 6, "draw06", ex(2, 8, 8'h3F, 6, 1, 0));
        num2(0, 7, "draw07", ex(2, 8, 8'h7F, 7, 1, 0));
        num2(0, 8, "draw08_bingo", ex(3, 8, 8'hFF, 8, 1, 0));
        num2(0, 1, "done01", ex(3, 8, 8'hFF, 8, 0, 0));
        cmd(11, "restart", ex(0, 0, 0, 0, 0, 0));
        cmd(10, "erase0", ex(0, 0, 0, 0, 0, 1));

        for (int i = 1; i <= 8; i++)
            num2(0, i, "reload", ex((i == 8) ? 1 : 0, i, 0, i, 0, 0));
        cmd(11, "start2", ex(2, 8, 0, 8, 0, 0));
        for (int i = 1; i <= 4; i++)
            num2(0, i, "draw_pre_rst", ex(2, 8, (1 << i) - 1, i, 1, 0));

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        reset_check("async_rst");
        key_count = 2'd0;
        key_pair  = 8'h00;
        mon_kc    = 2'd0;
        cur       = '0;
        @(negedge clk);
        rst = 1'b0;
        num2(0, 9, "post_rst", ex(0, 1, 0, 9, 0, 0));

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, required 0",
                     q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
